pipe_ctrl: RTL

Parametrised pipeline control unit for the multi-issue core, replacing the fixed two-lane, seven-stage controller. Collects per-lane, per-stage stall requests and per-lane exception reports. Drives registered per-lane stall masks, a multi-cycle flush and an exception redirect PC from a vector table. Sits beside the pipeline stages; its outputs feed every stage register and the PC generator.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_ctrl_if.sv | 31 +++
 rtl/pipe_ctrl_exc_arbiter.sv | 35 +++
 rtl/pipe_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline control unit.
// Holds the FSM state encoding, the default vector address and the stall-mask builder.
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int          EXC_NONE         = 0;
  localparam logic [31:0] VEC_BASE_DEFAULT = 32'h0000000c;
  localparam int          MAX_STAGES       = 64;

  // Bits [stage_index:0] set; stage_index < 0 yields an empty mask.
  function automatic logic [MAX_STAGES-1:0] thermo_mask(input int stage_index, input int stages);
    logic [MAX_STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      if (i <= stage_index && i < stages) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of stall/exception inputs and control outputs between the pipeline and pipe_ctrl.
// The slave modport is the controller's view; master is the pipeline/PC-generator view.
interface pipe_ctrl_if #(
  parameter int LANES  = 2,
  parameter int STAGES = 7,
  parameter int EXC_W  = 2,
  parameter int ADDR_W = 32
);

  logic [LANES*STAGES-1:0] stallreq_i;
  logic [LANES*EXC_W-1:0]  excepttype_i;
  logic [LANES*ADDR_W-1:0] except_pc_i;
  logic [LANES*STAGES-1:0] stall_o;
  logic                    flush_o;
  logic [ADDR_W-1:0]       new_pc_o;
  logic                    new_pc_valid_o;
  logic [ADDR_W-1:0]       epc_o;
  logic [EXC_W-1:0]        ecode_o;
  logic                    busy_o;

  modport master (
    output stallreq_i, excepttype_i, except_pc_i,
    input  stall_o, flush_o, new_pc_o, new_pc_valid_o, epc_o, ecode_o, busy_o
  );

  modport slave (
    input  stallreq_i, excepttype_i, except_pc_i,
    output stall_o, flush_o, new_pc_o, new_pc_valid_o, epc_o, ecode_o, busy_o
  );

endinterface

// File: rtl/pipe_ctrl_exc_arbiter.sv
// Combinational lowest-lane-first exception select.
// Reports whether any lane raised an exception, and the winning lane, code and PC.
module exc_arbiter
  import pipe_ctrl_pkg::*;
#(
  parameter  int LANES  = 2,
  parameter  int EXC_W  = 2,
  parameter  int ADDR_W = 32,
  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES*EXC_W-1:0]  i_excepttype,
  input  logic [LANES*ADDR_W-1:0] i_except_pc,
  output logic                    o_valid,
  output logic [LIDX_W-1:0]       o_lane,
  output logic [EXC_W-1:0]        o_code,
  output logic [ADDR_W-1:0]       o_pc
);

  // Scan from the top lane down so the lowest requesting lane is written last.
  always_comb begin
    o_valid = 1'b0;
    o_lane  = '0;
    o_code  = '0;
    o_pc    = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (i_excepttype[l*EXC_W +: EXC_W] != EXC_W'(EXC_NONE)) begin
        o_valid = 1'b1;
        o_lane  = LIDX_W'(l);
        o_code  = i_excepttype[l*EXC_W +: EXC_W];
        o_pc    = i_except_pc[l*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: registered per-lane stall masks, multi-cycle flush on exception
// and a redirect PC taken from a strided vector table.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int               LANES        = 2,
  parameter int               STAGES       = 7,
  parameter int               EXC_W        = 2,
  parameter int               ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE    = ADDR_W'(VEC_BASE_DEFAULT),
  parameter logic [ADDR_W-1:0] VEC_STRIDE  = '0,
  parameter int               FLUSH_CYCLES = 1,
  parameter bit               LOCKSTEP     = 1'b1
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W  = 4;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [LANES*STAGES-1:0] r_stall;
  logic                    r_flush;
  logic [ADDR_W-1:0]       r_new_pc;
  logic                    r_new_pc_valid;
  logic [ADDR_W-1:0]       r_epc;
  logic [EXC_W-1:0]        r_ecode;

  logic                    w_exc_valid;
  logic [LIDX_W-1:0]       w_exc_lane;
  logic [EXC_W-1:0]        w_exc_code;
  logic [ADDR_W-1:0]       w_exc_pc;
  logic [ADDR_W-1:0]       w_code_idx;
  logic [ADDR_W-1:0]       w_vec_pc;

  logic [STAGES-1:0]       w_lane_mask [LANES];
  logic [STAGES-1:0]       w_or_mask;
  logic [LANES*STAGES-1:0] w_stall_next;

  exc_arbiter #(
    .LANES  (LANES),
    .EXC_W  (EXC_W),
    .ADDR_W (ADDR_W)
  ) u_arb (
    .i_excepttype (bus.excepttype_i),
    .i_except_pc  (bus.except_pc_i),
    .o_valid      (w_exc_valid),
    .o_lane       (w_exc_lane),
    .o_code       (w_exc_code),
    .o_pc         (w_exc_pc)
  );

  // Code 1 maps to VEC_BASE; the product wraps naturally at ADDR_W bits.
  assign w_code_idx = ADDR_W'(w_exc_code) - ADDR_W'(1);
  assign w_vec_pc   = VEC_BASE + w_code_idx * VEC_STRIDE;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [STAGES-1:0] w_req;
    int                w_smax;

    assign w_req = bus.stallreq_i[gi*STAGES +: STAGES];

    always_comb begin
      w_smax = -1;
      for (int s = 0; s < STAGES; s++) begin
        if (w_req[s]) w_smax = s;
      end
    end

    assign w_lane_mask[gi] = STAGES'(thermo_mask(w_smax, STAGES));
    assign w_stall_next[gi*STAGES +: STAGES] = LOCKSTEP ? w_or_mask : w_lane_mask[gi];
  end

  always_comb begin
    w_or_mask = '0;
    for (int l = 0; l < LANES; l++) begin
      w_or_mask = w_or_mask | w_lane_mask[l];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_stall        <= '0;
      r_flush        <= 1'b0;
      r_new_pc       <= '0;
      r_new_pc_valid <= 1'b0;
      r_epc          <= '0;
      r_ecode        <= '0;
    end else begin
      r_new_pc_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // An exception outranks any stall request sampled on the same edge.
          if (w_exc_valid) begin
            r_state        <= FLUSH;
            r_cnt          <= CNT_W'(FLUSH_CYCLES - 1);
            r_stall        <= '0;
            r_flush        <= 1'b1;
            r_new_pc       <= w_vec_pc;
            r_new_pc_valid <= 1'b1;
            r_epc          <= w_exc_pc;
            r_ecode        <= w_exc_code;
          end else begin
            r_stall <= w_stall_next;
          end
        end
        FLUSH: begin
          r_stall <= '0;
          if (r_cnt == '0) begin
            r_state  <= IDLE;
            r_flush  <= 1'b0;
            r_new_pc <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.stall_o        = r_stall;
  assign bus.flush_o        = r_flush;
  assign bus.new_pc_o       = r_new_pc;
  assign bus.new_pc_valid_o = r_new_pc_valid;
  assign bus.epc_o          = r_epc;
  assign bus.ecode_o        = r_ecode;
  assign bus.busy_o         = (r_state == FLUSH);

  a_arb_lane_code: assert property (@(posedge clk) disable iff (rst)
    w_exc_valid |-> (bus.excepttype_i[w_exc_lane*EXC_W +: EXC_W] == w_exc_code));

endmodule
